// File: rtl/aes128_key_expander.sv
// aes128_key_expander: iterative AES-128 key schedule with an 11-entry round-key store.
// One round key is derived per clock. A decryption datapath reads keys back by index,
// last round first.
//
// Parameters:
//   RD_REG : 0 = rd_key_o combinational from rd_round_i, 1 = registered (1-cycle latency)
//   NR     : number of rounds, only 10 (AES-128) is meaningful
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   zeroize_i    clears all stored keys (only when AES_KEYEXP_ZEROIZE_EN is defined)
//   key_in_i     128-bit cipher key, byte 0 = key_in_i[127:120]
//   key_valid_i  key_in_i valid
//   key_ready_o  block can accept a key
//   keys_valid_o round keys 0..10 complete and stable
//   busy_o       expansion in progress
//   rd_round_i   round-key index to read, 0..10 (larger indices read as zero)
//   rd_key_o     selected round key
//
// Build option: define AES_KEYEXP_ZEROIZE_EN to add the zeroize_i port.

module aes128_key_expander #(
  parameter int unsigned RD_REG = 0,
  parameter int unsigned NR     = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic         zeroize_i,
`endif
  input  logic [127:0] key_in_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  output logic         keys_valid_o,
  output logic         busy_o,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o
);

  localparam int unsigned NumKeys = 11;

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           key_ready_q, key_ready_d;
  logic           keys_valid_q, keys_valid_d;
  logic           busy_q, busy_d;
  logic [127:0]   rk_q [NumKeys];

  logic           wr_en, clr_all;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;

  // Round datapath: rk[rnd] = f(rk[rnd-1], rcon[rnd])
  logic [3:0]     prev_idx;
  logic [127:0]   prev_key, next_key;
  logic [31:0]    w0, w1, w2, w3, rot_w, sub_w, n0, n1, n2, n3;
  logic [7:0]     rcon;

  assign prev_idx = rnd_q - 4'd1;
  assign prev_key = (prev_idx < 4'd11) ? rk_q[prev_idx] : '0;
  assign {w0, w1, w2, w3} = prev_key;
  assign rot_w = {w3[23:0], w3[31:24]};
  // Four byte S-box lookups form SubWord
  assign sub_w = {Sbox[rot_w[31:24]], Sbox[rot_w[23:16]], Sbox[rot_w[15:8]], Sbox[rot_w[7:0]]};

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign n0 = w0 ^ sub_w ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    key_ready_d  = key_ready_q;
    keys_valid_d = keys_valid_q;
    busy_d       = busy_q;
    wr_en        = 1'b0;
    wr_idx       = rnd_q;
    wr_data      = next_key;
    clr_all      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // key_ready is registered so it first rises one edge after reset release
        key_ready_d = 1'b1;
        if (key_valid_i && key_ready_q) begin
          wr_en        = 1'b1;
          wr_idx       = 4'd0;
          wr_data      = key_in_i;
          rnd_d        = 4'd1;
          keys_valid_d = 1'b0;
          busy_d       = 1'b1;
          key_ready_d  = 1'b0;
          state_d      = StExpand;
        end
      end
      StExpand: begin
        wr_en = 1'b1;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == NR[3:0]) begin
          state_d      = StDone;
          keys_valid_d = 1'b1;
          busy_d       = 1'b0;
          key_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef AES_KEYEXP_ZEROIZE_EN
    // Zeroize wins over a simultaneous accept; that key is dropped
    if (zeroize_i) begin
      clr_all      = 1'b1;
      wr_en        = 1'b0;
      rnd_d        = 4'd0;
      keys_valid_d = 1'b0;
      busy_d       = 1'b0;
      key_ready_d  = 1'b1;
      state_d      = StIdle;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rnd_q        <= 4'd0;
      key_ready_q  <= 1'b0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NumKeys; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      key_ready_q  <= key_ready_d;
      keys_valid_q <= keys_valid_d;
      busy_q       <= busy_d;
      if (clr_all) begin
        for (int i = 0; i < NumKeys; i++) rk_q[i] <= '0;
      end else if (wr_en) begin
        rk_q[wr_idx] <= wr_data;
      end
    end
  end

  assign key_ready_o  = key_ready_q;
  assign keys_valid_o = keys_valid_q;
  assign busy_o       = busy_q;

  logic [127:0] rd_sel;
  assign rd_sel = (rd_round_i <= 4'd10) ? rk_q[rd_round_i] : '0;

  if (RD_REG != 0) begin : g_rd_reg
    logic [127:0] rd_key_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_key_q <= '0;
      else         rd_key_q <= rd_sel;
    end
    assign rd_key_o = rd_key_q;
  end else begin : g_rd_comb
    assign rd_key_o = rd_sel;
  end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Directed bench for aes128_key_expander (default RD_REG=0) using FIPS-197 vectors.
module tb_aes128_key_expander;

  localparam logic [127:0] KeyFips  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Rk1Fips  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Rk2Fips  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] Rk10Fips = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Rk1Zero  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Rk10Zero = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, keys_valid, busy;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  aes128_key_expander dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize_i   (zeroize),
`endif
    .key_in_i    (key_in),
    .key_valid_i (key_valid),
    .key_ready_o (key_ready),
    .keys_valid_o(keys_valid),
    .busy_o      (busy),
    .rd_round_i  (rd_round),
    .rd_key_o    (rd_key)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] exp, input string tag);
    rd_round = r;
    @(negedge clk);
    check(tag, rd_key, exp);
  endtask

  // Accept key k at the next edge, check E0 status, then count edges until keys_valid.
  task automatic expand(input logic [127:0] k, output int n);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("e0_busy", {127'd0, busy}, 128'd1);
    check("e0_ready", {127'd0, key_ready}, 128'd0);
    check("e0_kvalid", {127'd0, keys_valid}, 128'd0);
    n = 0;
    while (!keys_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_ready", {127'd0, key_ready}, 128'd0);
    check("rst_kvalid", {127'd0, keys_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_rdkey", rd_key, 128'd0);
    #11 rst_n = 1'b1;
    #1;
    check("ready_before_edge", {127'd0, key_ready}, 128'd0);
    tick();
    check("ready_after_edge", {127'd0, key_ready}, 128'd1);

    // Case 1: FIPS-197 key
    expand(KeyFips, lat);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_ready", {127'd0, key_ready}, 128'd1);
    check("c1_busy", {127'd0, busy}, 128'd0);
    rd(4'd0, KeyFips, "c1_rk0");
    rd(4'd1, Rk1Fips, "c1_rk1");
    rd(4'd2, Rk2Fips, "c1_rk2");
    rd(4'd10, Rk10Fips, "c1_rk10");

    // Case 2: zero key, accepted directly from DONE
    expand(128'd0, lat);
    check("c2_latency", 128'(lat), 128'd10);
    rd(4'd0, 128'd0, "c2_rk0");
    rd(4'd1, Rk1Zero, "c2_rk1");
    rd(4'd10, Rk10Zero, "c2_rk10");
    for (int r = 11; r < 16; r++) rd(4'(r), 128'd0, $sformatf("c2_rd%0d", r));

    // Case 3: key_valid held with changing key_in during expansion
    key_in    = KeyFips;
    key_valid = 1'b1;
    tick();
    lat = 0;
    while (!keys_valid && lat < 20) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    key_valid = 1'b0;
    check("c3_latency", 128'(lat), 128'd10);
    rd(4'd0, KeyFips, "c3_rk0");
    rd(4'd1, Rk1Fips, "c3_rk1");
    rd(4'd10, Rk10Fips, "c3_rk10");

    // Case 4: reset pulsed mid-expansion
    key_in    = 128'd0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    check("c4_busy_mid", {127'd0, busy}, 128'd1);
    check("c4_ready_mid", {127'd0, key_ready}, 128'd0);
    rst_n = 1'b0;
    #1;
    check("c4_rst_busy", {127'd0, busy}, 128'd0);
    check("c4_rst_ready", {127'd0, key_ready}, 128'd0);
    check("c4_rst_kvalid", {127'd0, keys_valid}, 128'd0);
    rd(4'd0, 128'd0, "c4_rst_rk0");
    rd(4'd1, 128'd0, "c4_rst_rk1");
    #2 rst_n = 1'b1;
    tick();
    check("c4_ready_again", {127'd0, key_ready}, 128'd1);
    expand(KeyFips, lat);
    check("c4_latency", 128'(lat), 128'd10);
    rd(4'd1, Rk1Fips, "c4_rk1");
    rd(4'd10, Rk10Fips, "c4_rk10");

`ifdef AES_KEYEXP_ZEROIZE_EN
    // Zeroize in DONE, then zeroize together with an accept
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("z_kvalid", {127'd0, keys_valid}, 128'd0);
    check("z_ready", {127'd0, key_ready}, 128'd1);
    for (int r = 0; r < 11; r++) rd(4'(r), 128'd0, $sformatf("z_rk%0d", r));
    key_in    = KeyFips;
    key_valid = 1'b1;
    zeroize   = 1'b1;
    tick();
    key_valid = 1'b0;
    zeroize   = 1'b0;
    check("z_acc_busy", {127'd0, busy}, 128'd0);
    check("z_acc_ready", {127'd0, key_ready}, 128'd1);
    rd(4'd0, 128'd0, "z_acc_rk0");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
